axi_rd_responder: RTL and testbench

//  AXI4 read-channel responder (slave side) backed by an on-chip word RAM. It answers the burst

---
 rtl/axi_rd_pkg.sv | 28 ++
 rtl/axi_rd_addr_gen.sv | 38 +++
 rtl/axi_rd_responder.sv | 203 ++++++++++++++++++++
 tb/tb_axi_rd_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types for the AXI4 read responder: response codes, burst kinds and FSM states.
package axi_rd_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    BURST_INCR = 2'b01,
    BURST_WRAP = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    DATA
  } state_e;

  // A whole burst is rejected for an illegal beat size, an unknown burst type
  // or a WRAP length that does not give a power-of-two boundary.
  function automatic logic burst_error(input logic [1:0] burst,
                                       input logic [7:0] len,
                                       input logic [2:0] size);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (size > 3'd2) || !(burst inside {BURST_INCR, BURST_WRAP}) || bad_wrap;
  endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational beat address step (INCR / WRAP) and backing-RAM range check.
module axi_rd_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic [ADDR_WIDTH-1:0]        cur_addr,
  input  logic [7:0]                   len,
  input  logic [2:0]                   size,
  input  logic [1:0]                   burst,
  input  logic [ADDR_WIDTH-1:0]        check_addr,
  output logic [ADDR_WIDTH-1:0]        next_addr,
  output logic [$clog2(MEM_WORDS)-1:0] word_idx,
  output logic                         in_range
);

  localparam int WORD_AW = $clog2(MEM_WORDS);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] inc_addr;
  logic [ADDR_WIDTH-1:0] off;

  always_comb begin
    incr      = ADDR_WIDTH'(1) << size;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    inc_addr  = cur_addr + incr;
    // WRAP keeps the bits above the boundary and lets only the low part roll over.
    next_addr = (burst == BURST_WRAP) ? ((cur_addr & ~wrap_mask) | (inc_addr & wrap_mask))
                                      : inc_addr;
    off       = check_addr - BASE_ADDR;
    word_idx  = off[WORD_AW+1:2];
    in_range  = (off >> 2) < ADDR_WIDTH'(MEM_WORDS);
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel slave over an on-chip word RAM, one burst outstanding.
// Build option: define AXI_RD_WRAP_EN to add the arburst port and WRAP bursts.
module axi_rd_responder
  import axi_rd_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    MEM_WORDS    = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
`ifdef AXI_RD_WRAP_EN
  input  logic [1:0]                   arburst,
`endif
  input  logic                         arvalid,
  output logic                         arready,
  output logic [31:0]                  rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [31:0]                  mem_wdata
);

  localparam int WORD_AW = $clog2(MEM_WORDS);
  localparam int CNT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  logic [31:0] mem [MEM_WORDS];

  state_e                state_q,   state_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [7:0]            len_q,     len_d;
  logic [2:0]            size_q,    size_d;
  logic [1:0]            burst_q,   burst_d;
  logic                  err_q,     err_d;
  logic [7:0]            beat_q,    beat_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic                  rlast_q,   rlast_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [31:0]           rdata_q,   rdata_d;

  logic [1:0]            burst_in;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [WORD_AW-1:0]    load_idx;
  logic                  load_in_range;
  logic                  load_burst_err;
  logic                  load_err;
  logic                  load_en;

`ifdef AXI_RD_WRAP_EN
  assign burst_in = arburst;
`else
  assign burst_in = BURST_INCR;
`endif

  axi_rd_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .cur_addr  (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .check_addr(load_addr),
    .next_addr (next_addr),
    .word_idx  (load_idx),
    .in_range  (load_in_range)
  );

  // NOTE: the RAM has no reset; its contents must survive rst and it maps to plain storage.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign load_err = load_burst_err | ~load_in_range;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    size_d         = size_q;
    burst_d        = burst_q;
    err_d          = err_q;
    beat_d         = beat_q;
    cnt_d          = cnt_q;
    arready_d      = arready_q;
    rvalid_d       = rvalid_q;
    rlast_d        = rlast_q;
    rresp_d        = rresp_q;
    rdata_d        = rdata_q;
    load_addr      = addr_q;
    load_burst_err = err_q;
    load_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        load_addr      = araddr;
        load_burst_err = burst_error(burst_in, arlen, arsize);
        if (arvalid && arready_q) begin
          addr_d    = araddr;
          len_d     = arlen;
          size_d    = arsize;
          burst_d   = burst_in;
          err_d     = load_burst_err;
          beat_d    = '0;
          cnt_d     = '0;
          arready_d = 1'b0;
          if (READ_LATENCY == 0) begin
            state_d = DATA;
            load_en = 1'b1;
            rlast_d = (arlen == 8'd0);
          end else begin
            state_d = LAT;
          end
        end
      end
      LAT: begin
        if (int'(cnt_q) == READ_LATENCY - 1) begin
          state_d = DATA;
          load_en = 1'b1;
          rlast_d = (len_q == 8'd0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        // rvalid is always high here, so rready alone marks the handshake.
        load_addr = next_addr;
        if (rready) begin
          if (rlast_q) begin
            state_d   = IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 8'd1;
            load_en = 1'b1;
            rlast_d = ((beat_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_en) begin
      rvalid_d = 1'b1;
      rresp_d  = load_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = load_err ? 32'h0 : mem[load_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_INCR;
      err_q     <= 1'b0;
      beat_q    <= '0;
      cnt_q     <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: table of bursts checked through a beat scoreboard,
// plus hand sequences for write collision, back-to-back, reset abort and (AXI_RD_WRAP_EN) WRAP.
module tb_axi_rd_responder;

  localparam int          MEM_WORDS = 4096;
  localparam logic [31:0] BASE      = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        mem_we;
  logic [11:0] mem_waddr;
  logic [31:0] mem_wdata;

  always #5 clk = ~clk;

  axi_rd_responder #(
    .ADDR_WIDTH  (32),
    .MEM_WORDS   (MEM_WORDS),
    .BASE_ADDR   (BASE),
    .READ_LATENCY(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
`ifdef AXI_RD_WRAP_EN
    .arburst  (arburst),
`endif
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  pattern;   // rready sequence per presented beat, bit 0 first
    int          exp_lat;   // cycles from AR handshake to first rvalid
    int          exp_errs;  // number of SLVERR beats
  } rec_t;

  rec_t        tbl[8];
  logic [34:0] sb_q[$];     // {rdata, rresp, rlast}
  logic [31:0] model_mem [MEM_WORDS];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] exp_beat(input logic [31:0] a, input logic [2:0] size,
                                           input logic last);
    logic [31:0] off;
    logic        err;
    off = a - BASE;
    err = (size > 3'd2) || (off >= 32'(4 * MEM_WORDS));
    return {err ? 32'h0 : model_mem[int'(off >> 2)], err ? 2'b10 : 2'b00, last};
  endfunction

  // Called on a negedge; returns on the negedge after the AR handshake edge.
  task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst);
    int n = 0;
    araddr  = a;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) check("ar_timeout", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Drains the scoreboard, checking every handshaked beat and stall stability.
  task automatic collect(input logic [3:0] pat, input int lat, input int len, output int nerr);
    int          cyc = 1, k = 0, got = 0, first = -1, last_cyc = -1, total;
    logic        stalled = 1'b0;
    logic [34:0] held, cur, exp;
    nerr  = 0;
    total = sb_q.size();
    while (got < total && cyc < 200) begin
      rready = pat[k % 4];
      if (rvalid) begin
        k++;
        if (first < 0) first = cyc;
        cur = {rdata, rresp, rlast};
        if (stalled) check("stall_hold", 64'(cur), 64'(held));
        if (rready) begin
          exp = sb_q.pop_front();
          check("beat", 64'(cur), 64'(exp));
          if (rresp == 2'b10) nerr++;
          got++;
          last_cyc = cyc;
          stalled  = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = cur;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    if (got < total) begin
      check("r_timeout", 64'(got), 64'(total));
      sb_q.delete();
    end
    if (lat > 0) check("first_latency", 64'(first), 64'(lat));
    if (pat == 4'hF) check("burst_span", 64'(last_cyc - first), 64'(len));
    check("idle_after", {62'd0, rvalid, arready}, 64'b01);
  endtask

  task automatic run_burst(input rec_t r);
    logic [31:0] a;
    int          nerr;
    a = r.addr;
    for (int b = 0; b <= int'(r.len); b++) begin
      sb_q.push_back(exp_beat(a, r.size, b == int'(r.len)));
      a = a + (32'd1 << r.size);
    end
    do_ar(r.addr, r.len, r.size, 2'b01);
    collect(r.pattern, r.exp_lat, int'(r.len), nerr);
    check("slverr_count", 64'(nerr), 64'(r.exp_errs));
  endtask

  initial begin
    int          n, beats_done, nerr;
    logic [31:0] old_word;

    tbl[0] = '{32'h0000_0000, 8'd7, 3'd2, 4'b1111, 3, 0};  // plain 8-beat INCR
    tbl[1] = '{32'h0000_0000, 8'd7, 3'd2, 4'b1001, 3, 0};  // rready 1-0-0-1
    tbl[2] = '{32'h0000_3FF8, 8'd3, 3'd2, 4'b1111, 3, 2};  // runs off the top of RAM
    tbl[3] = '{32'h0000_0100, 8'd3, 3'd3, 4'b1111, 3, 4};  // illegal arsize
    tbl[4] = '{32'h0000_0041, 8'd5, 3'd0, 4'b1111, 3, 0};  // byte beats
    tbl[5] = '{32'h0000_3FFE, 8'd2, 3'd1, 4'b1011, 3, 2};  // halfwords crossing the end
    tbl[6] = '{32'hFFFF_FFFC, 8'd1, 3'd2, 4'b1111, 3, 1};  // address wraps to 0
    tbl[7] = '{32'h0000_0020, 8'd0, 3'd2, 4'b1111, 3, 0};  // single beat

    rst = 1'b1; araddr = '0; arlen = '0; arsize = '0; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {27'd0, arready, rvalid, rlast, rresp, rdata}, {27'd0, 5'b10000, 32'h0});

    for (int i = 0; i < MEM_WORDS; i++) begin
      mem_we = 1'b1; mem_waddr = 12'(i); mem_wdata = 32'(i) * 32'h11;
      model_mem[i] = 32'(i) * 32'h11;
      @(negedge clk);
    end
    mem_we = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 8; t++) run_burst(tbl[t]);

    // Write colliding with the first-beat load returns the old word; a write while the
    // beat is stalled leaves the presented data alone and shows up on the next read.
    old_word = model_mem[32];
    rready   = 1'b0;
    do_ar(32'h80, 8'd1, 3'd2, 2'b01);
    @(negedge clk);
    mem_we = 1'b1; mem_waddr = 12'd32; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("collide_old", {31'd0, rvalid, rdata}, {31'd0, 1'b1, old_word});
    mem_wdata = 32'hCAFE_0000;
    @(negedge clk);
    mem_we = 1'b0;
    check("stalled_unchanged", {32'd0, rdata}, {32'd0, old_word});
    rready = 1'b1;
    @(negedge clk);
    check("collide_beat1", {31'd0, rlast, rdata}, {31'd0, 1'b1, model_mem[33]});
    @(negedge clk);
    rready = 1'b0;
    model_mem[32] = 32'hCAFE_0000;
    run_burst('{32'h0000_0080, 8'd0, 3'd2, 4'b1111, 3, 0});

    // Back-to-back single beats with arvalid held throughout.
    rready = 1'b1; araddr = 32'h20; arlen = 8'd0; arsize = 3'd2; arvalid = 1'b1;
    @(negedge clk);
    check("b2b_busy", 64'(arready), 64'd0);
    araddr = 32'h24;
    @(negedge clk);
    @(negedge clk);
    check("b2b_first", {30'd0, rvalid, rlast, rdata}, {30'd0, 2'b11, model_mem[8]});
    @(negedge clk);
    check("b2b_rearm", {62'd0, arready, rvalid}, 64'b10);
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_second", {30'd0, rvalid, rlast, rdata}, {30'd0, 2'b11, model_mem[9]});
    @(negedge clk);
    rready = 1'b0;
    check("b2b_idle", {62'd0, arready, rvalid}, 64'b10);

    // Reset while beat 3 of an 8-beat burst is presented.
    rready = 1'b1;
    do_ar(32'h0, 8'd7, 3'd2, 2'b01);
    beats_done = 0;
    n = 0;
    while (n < 100) begin
      if (rvalid) begin
        if (beats_done == 3) break;
        beats_done++;
      end
      @(negedge clk);
      n++;
    end
    check("reach_beat3", 64'(beats_done), 64'd3);
    rst    = 1'b1;
    rready = 1'b0;
    @(negedge clk);
    check("rst_abort", {62'd0, rvalid, arready}, 64'b01);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_no_beats", {62'd0, rvalid, arready}, 64'b01);
    run_burst(tbl[0]);

`ifdef AXI_RD_WRAP_EN
    sb_q.push_back({model_mem[6], 2'b00, 1'b0});
    sb_q.push_back({model_mem[7], 2'b00, 1'b0});
    sb_q.push_back({model_mem[4], 2'b00, 1'b0});
    sb_q.push_back({model_mem[5], 2'b00, 1'b1});
    do_ar(32'h18, 8'd3, 3'd2, 2'b10);
    collect(4'hF, 3, 3, nerr);
    check("wrap_errs", 64'(nerr), 64'd0);
    for (int b = 0; b < 3; b++) sb_q.push_back({32'h0, 2'b10, b == 2});
    do_ar(32'h18, 8'd2, 3'd2, 2'b10);
    collect(4'hF, 3, 2, nerr);
    check("wrap_badlen_errs", 64'(nerr), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
